// File: rtl/muldiv_unit.sv
// Multi-cycle RISC-V M-extension multiply/divide unit. The multiplier is shift-add and the divider is restoring.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle combinational product.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = $clog2(XLEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic [2:0]            op_i,
  input  logic [XLEN-1:0]       reg1_i,
  input  logic [XLEN-1:0]       reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  output logic [XLEN-1:0]       result_o,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  stall_req_o,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                r_state;
  logic [2:0]            r_op;
  logic                  r_neg_q;
  logic                  r_neg_r;
  logic [XLEN-1:0]       r_opb;
  logic [2*XLEN-1:0]     r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [XLEN-1:0]       r_result;
  logic                  r_ready;
  logic                  r_wreg;
  logic [REG_ADDR_W-1:0] r_wd;

  logic                  w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0]       w_mag1, w_mag2;
  logic                  w_div_zero, w_div_ovf, w_fast;
  logic [2*XLEN-1:0]     w_fast_prod;
  logic [XLEN-1:0]       w_early_result;
  logic [XLEN:0]         w_sum, w_trial;
  logic [2*XLEN-1:0]     w_acc_next;

  // The accumulator holds magnitudes. Signs are restored only once the result is complete.
  function automatic logic [XLEN-1:0] f_finish(input logic [2:0] op, input logic neg_q,
                                               input logic neg_r, input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    prod = neg_q ? -acc : acc;
    quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (!op[2]) res = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else        res = op[1] ? rem : quo;
    return res;
  endfunction

  always_comb begin
    w_sgn1     = !(op_i[0] && (op_i[1] || op_i[2]));
    w_sgn2     = w_sgn1 && (op_i != 3'b010);
    w_neg1     = w_sgn1 && reg1_i[XLEN-1];
    w_neg2     = w_sgn2 && reg2_i[XLEN-1];
    w_mag1     = w_neg1 ? -reg1_i : reg1_i;
    w_mag2     = w_neg2 ? -reg2_i : reg2_i;
    w_div_zero = op_i[2] && (reg2_i == '0);
    w_div_ovf  = op_i[2] && w_sgn1 && (reg1_i == {1'b1, {(XLEN-1){1'b0}}}) && (reg2_i == '1);
`ifdef MULDIV_FAST_MUL_EN
    w_fast      = !op_i[2];
    w_fast_prod = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
`else
    w_fast      = 1'b0;
    w_fast_prod = '0;
`endif
    if (w_div_zero)     w_early_result = op_i[1] ? reg1_i : '1;
    else if (w_div_ovf) w_early_result = op_i[1] ? '0 : reg1_i;
    else                w_early_result = f_finish(op_i, w_neg1 ^ w_neg2, w_neg1, w_fast_prod);
  end

  // One iteration step. The multiply adds into the upper half and shifts right.
  // The divide shifts left and does a trial subtract.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{r_acc[0]}} & r_opb};
    w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_opb};
    if (!r_op[2])         w_acc_next = {w_sum, r_acc[XLEN-1:1]};
    else if (!w_trial[XLEN]) w_acc_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    else                  w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
      r_wreg   <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_ready <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_op    <= op_i;
            r_wd    <= wd_i;
            r_wreg  <= wreg_i;
            r_neg_q <= w_neg1 ^ w_neg2;
            r_neg_r <= w_neg1;
            r_opb   <= w_mag2;
            r_acc   <= {{XLEN{1'b0}}, w_mag1};
            r_cnt   <= '0;
            if (w_div_zero || w_div_ovf || w_fast) begin
              r_result <= w_early_result;
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (annul_i) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(XLEN - 1)) begin
              r_result <= f_finish(r_op, r_neg_q, r_neg_r, w_acc_next);
              r_ready  <= 1'b1;
              r_state  <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result_o    = r_result;
  assign ready_o     = r_ready && !annul_i;
  assign wreg_o      = r_wreg && ready_o;
  assign wd_o        = r_wd;
  assign busy_o      = (r_state != S_IDLE);
  assign stall_req_o = !annul_i && (((r_state == S_IDLE) && start_i) || (r_state == S_CALC));

endmodule
